bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Readout stage downstream of the stream-to-BRAM capture block.
- On a start command, reads `len` words from the 16-entry BRAM's synchronous read port, starting at `base_addr`, and emits them as an AXI4-Stream master with `tlast`.
- A 2-entry output buffer with credit-based read issue absorbs the 1-cycle BRAM latency and any backpressure. No word is dropped or duplicated.

Parameters:
- DATA_W, 32, stream and BRAM data width.
- ADDR_W, 4, BRAM address width.
- DEPTH, 16, BRAM word count; must equal 2**ADDR_W.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle command strobe; sampled only when busy=0.
- base_addr  input  ADDR_W  first BRAM address, latched at start.
- len  input  ADDR_W+1  word count, 0..DEPTH, latched at start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the transfer completes.
- bram_en  output  1  read enable to the BRAM.
- bram_addr  output  ADDR_W  read address.
- bram_dout  input  DATA_W  read data, valid exactly 1 cycle after bram_en.
- m_tdata  output  DATA_W  stream data.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  stream ready.
- m_tlast  output  1  high on the final beat.

Behaviour:
- Reset (asynchronous, effective immediately, any state): busy, done, bram_en, m_tvalid and m_tlast are 0; bram_addr, m_tdata and all counters are 0; buffer and in-flight count are cleared; FSM goes to IDLE.
- FSM states:
  - IDLE: on start with len>0, latch base_addr/len, set rd_cnt=0 and tx_cnt=0, go to RUN. On start with len=0, stay in IDLE, pulse done next cycle, emit no beats.
  - RUN: issue reads. When rd_cnt==len, go to DRAIN.
  - DRAIN: wait until tx_cnt==len, i.e. the last beat has been accepted. Then pulse done, drop busy and return to IDLE in the same cycle.
- Read issue in RUN: bram_en=1 in a cycle only if occ + inflight - pop < 2, where:
  - occ is the buffer occupancy;
  - inflight is 1 if bram_en was high in the previous cycle;
  - pop = m_tvalid & m_tready.
- bram_addr = (base_addr + rd_cnt) mod DEPTH; address wrap past DEPTH-1 to 0 is required. rd_cnt increments per issued read.
- Returned bram_dout is pushed into the buffer on the cycle after bram_en. The buffer must never overflow; a push into a full buffer is a design error, and the bench asserts against it.
- Stream rules:
  - m_tvalid=1 whenever occ>0; m_tdata is the buffer head.
  - Once m_tvalid rises, m_tvalid, m_tdata and m_tlast hold until m_tready=1.
  - A beat transfers on m_tvalid & m_tready; tx_cnt increments.
  - m_tlast=1 exactly when the head word is beat index len-1.
- Latency: start sampled at edge T0; bram_en high in cycle T0+1; m_tvalid high after edge T0+2.
- Throughput: with m_tready held high, one beat per cycle, with no bubbles after the first beat.
- Simultaneous push and pop leaves occ unchanged.
- start while busy=1 is ignored; latched parameters are unaffected.
- done and a new start on the same edge: the new start is accepted, since busy is already 0 in that cycle.

Optional Feature:
- Macro RD_SUM_EN.
- Defined:
  - adds output port sum_out (DATA_W), the modulo-2**DATA_W sum of all m_tdata beats accepted in the current/last transfer;
  - sum_out clears to 0 on reset and on an accepted start, and holds its value after done.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
- BRAM preloaded with 100..115; start base=0 len=16, m_tready=1 -> 16 consecutive beats 100..115, m_tlast only on 115, done pulse 1 cycle after the last beat, busy low afterwards.
- Same transfer with m_tready toggling 1,0,0,1 repeating -> same 16 values in order, no drops or duplicates, data stable while stalled, buffer never overflows.
- base=14 len=4 -> bram_addr sequence 14,15,0,1; beats 114,115,100,101; m_tlast on 101.
- start len=0 -> no bram_en, no beats, done pulse one cycle later; start pulsed mid-transfer (base=5) -> ignored, original stream completes unchanged.
- Assert rst_n low after 6 beats with m_tvalid=1 -> m_tvalid and busy drop immediately; after release, a new base=0 len=2 transfer yields 100,101.
- With RD_SUM_EN: base=0 len=16 -> sum_out=1720 after done; a following start clears sum_out to 0.

Source files
------------

// File: rtl/bram_stream_reader.sv
// BRAM readout stage: streams `len` words starting at `base_addr` as an AXI4-Stream master.
// Optional RD_SUM_EN adds sum_out, the running sum of accepted beats for the current/last transfer.
module bram_stream_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
`ifdef RD_SUM_EN
  output logic [DATA_W-1:0] sum_out,
`endif
  output logic              m_tlast
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic [ADDR_W:0]   rd_cnt_d;
  logic [ADDR_W:0]   tx_cnt_q;
  logic [ADDR_W:0]   tx_cnt_d;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic [DATA_W-1:0] buf_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        occ_q;
  logic [ADDR_W:0]   addr_sum_s;
  logic [2:0]        level_s;
  logic              pop_s;
  logic              push_s;
  logic              start_acc_s;

  assign start_acc_s = (state_q == IDLE) && start;
  assign pop_s       = m_tvalid && m_tready;
  assign push_s      = inflight_q;
  assign rd_cnt_d    = rd_cnt_q + {{ADDR_W{1'b0}}, bram_en};
  assign tx_cnt_d    = tx_cnt_q + {{ADDR_W{1'b0}}, pop_s};

  // Address wraps modulo DEPTH; the sum never reaches 2*DEPTH.
  assign addr_sum_s = {1'b0, base_q} + rd_cnt_q;
  assign bram_addr  = (addr_sum_s >= DEPTH_L) ? (addr_sum_s[ADDR_W-1:0] - DEPTH_L[ADDR_W-1:0])
                                              : addr_sum_s[ADDR_W-1:0];

  assign busy     = busy_q;
  assign done     = done_q;
  assign m_tvalid = (occ_q != 2'd0);
  assign m_tdata  = buf_q[rd_ptr_q];
  assign m_tlast  = m_tvalid && (tx_cnt_q == (len_q - ONE_L));

  // Credit check: buffered words plus the read still in the BRAM, less this cycle's pop, must leave room.
  always_comb begin
    level_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    bram_en = 1'b0;
    if ((state_q == RUN) && (rd_cnt_q != len_q) && (level_s < 3'd2)) begin
      bram_en = 1'b1;
    end else begin
      bram_en = 1'b0;
    end
  end

  // Transfer control FSM with counters, busy and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= {ADDR_W{1'b0}};
      len_q    <= {(ADDR_W+1){1'b0}};
      rd_cnt_q <= {(ADDR_W+1){1'b0}};
      tx_cnt_q <= {(ADDR_W+1){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rd_cnt_q <= {(ADDR_W+1){1'b0}};
            tx_cnt_q <= {(ADDR_W+1){1'b0}};
            if (len != {(ADDR_W+1){1'b0}}) begin
              base_q  <= base_addr;
              len_q   <= len;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          rd_cnt_q <= rd_cnt_d;
          tx_cnt_q <= tx_cnt_d;
          if (rd_cnt_d == len_q) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          tx_cnt_q <= tx_cnt_d;
          // Finish on the edge that accepts the final beat so done follows it directly.
          if (tx_cnt_d == len_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Two-entry output buffer fed by the BRAM one cycle after each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      buf_q[0]   <= {DATA_W{1'b0}};
      buf_q[1]   <= {DATA_W{1'b0}};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      inflight_q <= bram_en;
      if (push_s) begin
        buf_q[wr_ptr_q] <= bram_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

`ifdef RD_SUM_EN
  logic [DATA_W-1:0] sum_q;

  assign sum_out = sum_q;

  // Running sum of accepted beats, restarted by every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= {DATA_W{1'b0}};
    end else if (start_acc_s) begin
      sum_q <= {DATA_W{1'b0}};
    end else if (pop_s) begin
      sum_q <= sum_q + m_tdata;
    end else begin
      sum_q <= sum_q;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed + randomized bench for bram_stream_reader: a BRAM model feeds the DUT and
// a transaction-level model (expected word list, credit occupancy) checks every cycle.
module tb_bram_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_addr;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic        bram_en;
  logic [3:0]  bram_addr;
  logic [31:0] bram_dout;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
`ifdef RD_SUM_EN
  logic [31:0] sum_out;
`endif

  logic [31:0] mem [16];
  int checks = 0;
  int errors = 0;

  bram_stream_reader #(.DATA_W(32), .ADDR_W(4), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_dout (bram_dout),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
`ifdef RD_SUM_EN
    .sum_out   (sum_out),
`endif
    .m_tlast   (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready.
  // inject: cycle in which a stray start (base=5,len=3) is driven; abort: beat count at which reset hits.
  task automatic run_xfer(input int base, input int n, input int mode, input int inject,
                          input int abort_at, input bit b2b);
    int cyc, issued, acc, iss_k1, iss_k2, occ_m, last_cyc;
    bit en_prev, finished, complete, exp_en, pop_m;
    logic [31:0] exp_sum;
    cyc = 1; issued = 0; acc = 0; iss_k1 = 0; iss_k2 = 0; last_cyc = 0;
    en_prev = 1'b0; finished = 1'b0; exp_sum = 32'd0;
    if (!b2b) @(negedge clk);
    start = 1'b1; base_addr = 4'(base); len = 5'(n); m_tready = 1'b0;
    @(negedge clk);
    while (!finished && cyc < 200) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == inject) begin
        start = 1'b1; base_addr = 4'd5; len = 5'd3;
      end else begin
        start = 1'b0;
      end
      #1;
      occ_m    = iss_k2 - acc;
      complete = (n == 0) || (acc == n);
      pop_m    = (occ_m > 0) && m_tready;
      exp_en   = (n > 0) && (issued < n) && ((occ_m + int'(en_prev) - int'(pop_m)) < 2);
`ifdef RD_SUM_EN
      if (cyc == 1) chk("sum_clear", sum_out, 32'd0);
`endif
      chk("valid", m_tvalid, occ_m > 0);
      chk("occ_bound", occ_m <= 2, 1'b1);
      chk("bram_en", bram_en, exp_en);
      chk("busy", busy, !complete);
      chk("done", done, complete);
      if (bram_en) begin
        chk("addr", bram_addr, (base + issued) % 16);
        issued++;
      end
      if (abort_at >= 0 && acc == abort_at && m_tvalid) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", m_tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_en", bram_en, 1'b0);
        chk("rst_last", m_tlast, 1'b0);
        start = 1'b0;
        return;
      end
      if (mode == 0 && acc > 0 && acc < n) chk("no_bubble", m_tvalid, 1'b1);
      if (m_tvalid) begin
        chk("data", m_tdata, mem[(base + acc) % 16]);
        chk("last", m_tlast, acc == n - 1);
        if (m_tready) begin
          exp_sum = exp_sum + mem[(base + acc) % 16];
          acc++;
          last_cyc = cyc;
        end
      end
      if (complete) begin
        chk("done_lat", cyc, (n == 0) ? 1 : last_cyc + 1);
        chk("issued", issued, n);
`ifdef RD_SUM_EN
        chk("sum", sum_out, exp_sum);
`endif
        finished = 1'b1;
      end else begin
        iss_k2  = iss_k1;
        iss_k1  = issued;
        en_prev = bram_en;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!finished) chk("timeout", 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 4'd0; len = 5'd0; m_tready = 1'b0;
    bram_dout = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(100 + i);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_en", bram_en, 1'b0);
    chk("reset_addr", bram_addr, 4'd0);
    chk("reset_valid", m_tvalid, 1'b0);
    chk("reset_last", m_tlast, 1'b0);
    chk("reset_data", m_tdata, 32'd0);
`ifdef RD_SUM_EN
    chk("reset_sum", sum_out, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_xfer(0, 16, 0, -1, -1, 1'b0);
    run_xfer(0, 16, 1, -1, -1, 1'b0);
    run_xfer(14, 4, 0, -1, -1, 1'b0);
    run_xfer(0, 0, 0, -1, -1, 1'b0);
    run_xfer(3, 10, 0, 4, -1, 1'b0);
    run_xfer(0, 16, 1, 7, -1, 1'b0);
    run_xfer(0, 16, 0, -1, 6, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_xfer(0, 2, 0, -1, -1, 1'b0);
    run_xfer(9, 3, 2, -1, -1, 1'b0);
    run_xfer(0, 5, 0, -1, -1, 1'b1);
    run_xfer(0, 16, 0, -1, -1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_xfer(int'($urandom_range(0, 15)), int'($urandom_range(1, 16)), 2, -1, -1, 1'(t % 2));
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
